// File: rtl/q2_pkg.sv
// q2_pkg: shared op encodings, sequencer states and default width for the Q2 datapath
package q2_pkg;

   localparam int Q2_WIDTH = 12;

   localparam logic [1:0] Q2_OP_LOAD = 2'b00;
   localparam logic [1:0] Q2_OP_NOR  = 2'b01;
   localparam logic [1:0] Q2_OP_ADD  = 2'b10;
   localparam logic [1:0] Q2_OP_SHR  = 2'b11;

   typedef enum logic [1:0] {
      Q2_IDLE = 2'b00,
      Q2_RUN  = 2'b01,
      Q2_DONE = 2'b10
   } q2_state_e;

endpackage

// File: rtl/q2_alu.sv
// q2_alu: single-bit combinational ALU slice; the flag carries add carry, zero-detect or passthrough
module q2_alu (
   input  logic a0,
   input  logic x0,
   input  logic x1,
   input  logic f,
   input  logic o1,
   input  logic o0,
   output logic alu_out,
   output logic alu_cout
);

   // load/nor keep F as a running "all result bits zero" flag; shift leaves F untouched
   assign alu_out  = o1 ? (o0 ? x1 : a0 ^ x0 ^ f) : (o0 ? ~(a0 | x0) : x0);
   assign alu_cout = o1 ? (o0 ? f : (a0 & x0) | (f & (a0 ^ x0))) : (f & ~alu_out);

endmodule

// File: rtl/q2_alu_seq.sv
// q2_alu_seq: bit-serial sequencer feeding q2_alu LSB-first and returning a WIDTH-bit result
module q2_alu_seq
   import q2_pkg::*;
#(
   parameter int WIDTH = Q2_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] x_in,
   input  logic             f_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] a_out,
   output logic             f_out
);

   localparam int CW = $clog2(WIDTH) + 1;

   q2_state_e        state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, x_q, x_d;
   logic             f_q, f_d;
   logic [1:0]       op_q, op_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             alu_out, alu_cout, last, load;

   assign last  = cnt_q == CW'(WIDTH - 1);
   assign load  = start && state_q != Q2_RUN;
   assign a_out = a_q;
   assign f_out = f_q;

   // x1 is forced low on the final step so a shift brings in a zero MSB
   q2_alu u_alu (
      .a0       (a_q[0]),
      .x0       (x_q[0]),
      .x1       (last ? 1'b0 : x_q[1]),
      .f        (f_q),
      .o1       (op_q[1]),
      .o0       (op_q[0]),
      .alu_out  (alu_out),
      .alu_cout (alu_cout)
   );

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= Q2_IDLE;
      else        state_q <= state_d;
   end

   // next state: a load wins from IDLE or DONE, RUN leaves after the last bit
   always_comb begin
      state_d = load ? Q2_RUN : (state_q == Q2_RUN ? (last ? Q2_DONE : Q2_RUN) : Q2_IDLE);
   end

   // handshake outputs decoded from state
   always_comb begin
      busy = state_q == Q2_RUN;
      done = state_q == Q2_DONE;
   end

   // datapath next: load operands, or shift one result bit in per RUN cycle
   always_comb begin
      a_d   = a_q;
      x_d   = x_q;
      f_d   = f_q;
      op_d  = op_q;
      cnt_d = cnt_q;
      if (load) begin
         a_d   = a_in;
         x_d   = x_in;
         op_d  = op;
         cnt_d = '0;
         f_d   = op[1] ? f_in : 1'b1;
      end else if (state_q == Q2_RUN) begin
         a_d   = {alu_out, a_q[WIDTH-1:1]};
         x_d   = {1'b0, x_q[WIDTH-1:1]};
         f_d   = alu_cout;
         cnt_d = cnt_q + CW'(1);
      end
   end

   // datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q   <= '0;
         x_q   <= '0;
         f_q   <= 1'b0;
         op_q  <= Q2_OP_LOAD;
         cnt_q <= '0;
      end else begin
         a_q   <= a_d;
         x_q   <= x_d;
         f_q   <= f_d;
         op_q  <= op_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: tb/tb_q2_alu_seq.sv
// tb_q2_alu_seq: random and directed checks of q2_alu_seq against an arithmetic reference
module tb_q2_alu_seq;

   localparam int W = 12;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [1:0]   op = 2'b00;
   logic [W-1:0] a_in = '0, x_in = '0;
   logic         f_in = 1'b0;
   logic         busy, done, f_out;
   logic [W-1:0] a_out;

   int errors = 0;
   int checks = 0;

   q2_alu_seq #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .op    (op),
      .a_in  (a_in),
      .x_in  (x_in),
      .f_in  (f_in),
      .busy  (busy),
      .done  (done),
      .a_out (a_out),
      .f_out (f_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // returns {flag, word}
   function automatic logic [W:0] ref_op(input logic [1:0] o, input logic [W-1:0] a,
                                         input logic [W-1:0] x, input logic f);
      logic [W-1:0] r;
      case (o)
         2'b00: return {x == '0, x};
         2'b01: begin r = ~(a | x); return {r == '0, r}; end
         2'b10: return (W+1)'(a) + (W+1)'(x) + (W+1)'(f);
         default: return {f, x >> 1};
      endcase
   endfunction

   // drive operands and start, return #1 after the accepting edge with start low
   task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] x,
                         input logic f, output logic [W:0] exp);
      op = o; a_in = a; x_in = x; f_in = f; start = 1'b1;
      exp = ref_op(o, a, x, f);
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // wait for done, optionally pulsing a spurious start mid-run, and check result and latency
   task automatic wait_done(input string tag, input logic [W:0] exp, input bit poke);
      int n = 0;
      for (int i = 1; i <= W + 5 && n == 0; i++) begin
         if (poke && i == 5) begin
            start = 1'b1; op = 2'($urandom); a_in = W'($urandom); x_in = W'($urandom); f_in = 1'($urandom);
         end else start = 1'b0;
         @(posedge clk);
         #1;
         if (done) n = i;
      end
      start = 1'b0;
      check({tag, "_latency"}, 32'(n + 1), 32'(W + 1));
      check({tag, "_a"}, 32'(a_out), 32'(exp[W-1:0]));
      check({tag, "_f"}, 32'(f_out), 32'(exp[W]));
      check({tag, "_busy_done"}, 32'(busy), 32'(0));
   endtask

   // one idle cycle after DONE: done falls and the result is held
   task automatic idle_check(input string tag, input logic [W:0] exp);
      @(posedge clk);
      #1;
      check({tag, "_done_fall"}, 32'(done), 32'(0));
      check({tag, "_hold"}, 32'({f_out, a_out}), 32'(exp));
   endtask

   logic [W:0]   exp;
   logic [1:0]   d_op [7] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b00, 2'b11};
   logic [W-1:0] d_a  [7] = '{12'h7FF, 12'hFFF, 12'hFFF, 12'h0F0, 12'hFFF, 12'h5A5, 12'h123};
   logic [W-1:0] d_x  [7] = '{12'h001, 12'h001, 12'h001, 12'h00F, 12'h000, 12'h000, 12'h801};
   logic         d_f  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
   logic [W:0]   d_exp[7] = '{13'h0800, 13'h1000, 13'h1001, 13'h0F00, 13'h1000, 13'h1000, 13'h1400};

   initial begin
      #1;
      check("reset_async", 32'({busy, done, f_out, a_out}), 32'(0));
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("reset_idle", 32'({busy, done, f_out, a_out}), 32'(0));

      for (int i = 0; i < 7; i++) begin
         launch(d_op[i], d_a[i], d_x[i], d_f[i], exp);
         check($sformatf("dir%0d_model", i), 32'(exp), 32'(d_exp[i]));
         check($sformatf("dir%0d_busy", i), 32'(busy), 32'(1));
         wait_done($sformatf("dir%0d", i), d_exp[i], 1'b0);
         idle_check($sformatf("dir%0d", i), d_exp[i]);
      end

      launch(2'b10, 12'h7FF, 12'h001, 1'b0, exp);
      wait_done("poke", 13'h0800, 1'b1);
      idle_check("poke", 13'h0800);

      launch(2'b01, 12'h0F0, 12'h00F, 1'b0, exp);
      wait_done("b2b_first", 13'h0F00, 1'b0);
      launch(2'b10, 12'hFFF, 12'h001, 1'b1, exp);
      check("b2b_busy", 32'({busy, done}), 32'(2'b10));
      wait_done("b2b_second", 13'h1001, 1'b0);
      idle_check("b2b_second", 13'h1001);

      launch(2'b10, 12'h7FF, 12'h001, 1'b0, exp);
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      #1 check("rst_mid_run", 32'({busy, done, f_out, a_out}), 32'(0));
      for (int i = 0; i < W + 2; i++) begin
         @(posedge clk);
         #1 check("rst_no_done", 32'(done), 32'(0));
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      launch(2'b10, 12'h7FF, 12'h001, 1'b0, exp);
      wait_done("after_rst", 13'h0800, 1'b0);
      idle_check("after_rst", 13'h0800);

      for (int i = 0; i < 40; i++) begin
         launch(2'($urandom), W'($urandom), W'($urandom), 1'($urandom), exp);
         wait_done($sformatf("rnd%0d", i), exp, 1'($urandom));
         if ($urandom_range(0, 1) == 1) idle_check($sformatf("rnd%0d", i), exp);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
